// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM stream reader.
package ram_pkg;

   // Burst controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Output buffer depth and the width of its occupancy count
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned FIFO_CW    = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO; head entry drives the stream output directly.
module stream_fifo2
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH_P = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               push_i,
   input  logic [WIDTH_P-1:0] data_i,
   input  logic               pop_i,
   output logic [WIDTH_P-1:0] data_o,
   output logic               valid_o,
   output logic [FIFO_CW-1:0] count_o
);

   logic [WIDTH_P-1:0] head_q, head_d;
   logic [WIDTH_P-1:0] tail_q, tail_d;
   logic [FIFO_CW-1:0] count_q, count_d;
   logic               push_ok, pop_ok;

   // Next-state for head/tail entries and occupancy
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pop_ok  = pop_i && (count_q != '0);
      push_ok = push_i && ((count_q < FIFO_CW'(FIFO_DEPTH)) || pop_ok);
      case ({push_ok, pop_ok})
         2'b10: begin
            if (count_q == '0) head_d = data_i;
            else               tail_d = data_i;
            count_d = count_q + FIFO_CW'(1);
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - FIFO_CW'(1);
         end
         2'b11: begin
            if (count_q == FIFO_CW'(1)) begin
               head_d = data_i;
            end else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: ;
      endcase
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign data_o  = head_q;
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of words from a 1-cycle-latency RAM and streams them out
// through a 2-entry buffer with valid/ready handshake.
// Optional feature macro: RAM_READER_LAST_EN adds last_o on the final word.
module ram_stream_reader
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH_P = 32,
   parameter int unsigned DEPTH_P = 128,
   localparam int unsigned AW     = $clog2(DEPTH_P)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [AW-1:0]      base_addr_i,
   input  logic [AW:0]        len_i,
   output logic               ram_rd_en_o,
   output logic [AW-1:0]      ram_rd_addr_o,
   input  logic [WIDTH_P-1:0] ram_data_i,
   output logic [WIDTH_P-1:0] data_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               busy_o,
   output logic               done_o
`ifdef RAM_READER_LAST_EN
   ,
   output logic               last_o
`endif
);

   localparam int unsigned LW = AW + 1;

   state_e             state_q, state_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [LW-1:0]      rem_q, rem_d;
   logic               inflight_q, inflight_d;
   logic               done_zero_q, done_zero_d;

   logic [FIFO_CW-1:0] fifo_count;
   logic               fifo_valid;
   logic               pop_c;
   logic [2:0]         occ_c;
   logic               rd_en_c;
   logic               last_word_c;
   logic               final_xfer_c;

   // Read credit: a read may issue only if its word is sure to find room in the buffer
   always_comb begin
      pop_c        = fifo_valid && ready_i;
      occ_c        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);
      rd_en_c      = (state_q == READ) && (rem_q != '0) && (occ_c < 3'(FIFO_DEPTH));
      last_word_c  = (state_q == DRAIN) && !inflight_q && (fifo_count == FIFO_CW'(1));
      final_xfer_c = last_word_c && pop_c;
   end

   // Next-state: FSM, address counter, remaining count, in-flight flag
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      inflight_d  = rd_en_c;
      done_zero_d = 1'b0;

      if (rd_en_c) begin
         rem_d  = rem_q - LW'(1);
         addr_d = (addr_q == AW'(DEPTH_P - 1)) ? '0 : addr_q + AW'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i == '0) begin
                  done_zero_d = 1'b1;
               end else begin
                  state_d = READ;
                  addr_d  = base_addr_i;
                  rem_d   = len_i;
               end
            end
         end
         READ: begin
            if (rd_en_c && (rem_q == LW'(1))) state_d = DRAIN;
         end
         DRAIN: begin
            if (final_xfer_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         inflight_q  <= 1'b0;
         done_zero_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         inflight_q  <= inflight_d;
         done_zero_q <= done_zero_d;
      end
   end

   // Output buffer; captures RAM data the cycle after each issued read
   stream_fifo2 #(
      .WIDTH_P (WIDTH_P)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (inflight_q),
      .data_i  (ram_data_i),
      .pop_i   (pop_c),
      .data_o  (data_o),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   assign ram_rd_en_o   = rd_en_c;
   assign ram_rd_addr_o = addr_q;
   assign valid_o       = fifo_valid;
   assign busy_o        = (state_q != IDLE);
   assign done_o        = final_xfer_c | done_zero_q;

`ifdef RAM_READER_LAST_EN
   assign last_o = last_word_c;
`else
   // last_o not present in this build
`endif

endmodule
